// File: rtl/rocketcpu_pkg.sv
// Shared definitions for the RocketCPU interrupt dispatch slice.
// Holds the dispatcher FSM state encoding, the default register base and the
// register offsets of the interrupt controller (pending at +0, mask at +4).
package rocketcpu_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD_PEND = 3'd2,
    ST_CLR     = 3'd3,
    ST_DELIVER = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_BASE = 32'h0900_0000;
  localparam logic [31:0] OFS_PEND     = 32'd0;
  localparam logic [31:0] OFS_MASK     = 32'd4;

endpackage

// File: rtl/rocketcpu_prio_enc.sv
// Purpose: lowest-set-bit priority encoder, bit 0 has the highest priority.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req (SIZE request bits), idx (index of lowest set bit, 0 when none),
//        any (at least one request bit set).
module rocketcpu_prio_enc #(
  parameter int SIZE = 3,
  parameter int IW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic [SIZE-1:0] req,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rocketcpu_irq_dispatch.sv
// Purpose: Wishbone initiator that programs the irq mask, then on i_irq reads
//          the pending register, clears the lowest pending bit and hands its
//          index to a consumer (one vector per pass).
// Latency: vector valid one cycle after the clear-write ack; each Wishbone
//          transfer starts the cycle after its state is entered.
// Backpressure: o_vec_valid/o_vec_id hold until i_vec_ready; bus waits on
//          i_wb_ack (bounded by TIMEOUT when ROCKETCPU_IRQ_DISPATCH_TIMEOUT_EN
//          is defined, which also enables the sticky o_err flag).
// Ports: i_wb_clk/i_rst_n clock and async active-low reset; o_wb_adr/o_wb_dat/
//        o_wb_we/o_wb_cyc with i_wb_rdt/i_wb_ack form the Wishbone master;
//        i_irq aggregated interrupt; o_vec_valid/o_vec_id/i_vec_ready vector
//        handshake; o_err bus-timeout flag.
module rocketcpu_irq_dispatch
  import rocketcpu_pkg::*;
#(
  parameter int              SIZE      = 3,
  parameter logic [31:0]     BASE      = DEFAULT_BASE,
  parameter logic [SIZE-1:0] MASK_INIT = {SIZE{1'b1}},
  parameter int              TIMEOUT   = 16,
  parameter int              IW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic          i_wb_clk,
  input  logic          i_rst_n,
  output logic [31:0]   o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  input  logic          i_irq,
  output logic          o_vec_valid,
  output logic [IW-1:0] o_vec_id,
  input  logic          i_vec_ready,
  output logic          o_err
);

  state_t          state;
  logic [SIZE-1:0] clr_val;
  logic [IW-1:0]   sel_id;
  logic [IW-1:0]   enc_idx;
  logic            enc_any;
  logic            ack_q;
  logic            tmo;

  // Only the pending bits matter; the rest of the read word is don't-care.
  logic unused_rdt;
  assign unused_rdt = &{1'b0, i_wb_rdt[31:SIZE]};

  // A stray ack with no cycle outstanding is ignored.
  assign ack_q = i_wb_ack & o_wb_cyc;

  rocketcpu_prio_enc #(
    .SIZE (SIZE),
    .IW   (IW)
  ) u_prio_enc (
    .req (i_wb_rdt[SIZE-1:0]),
    .idx (enc_idx),
    .any (enc_any)
  );

`ifdef ROCKETCPU_IRQ_DISPATCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Counter idles at zero while cyc is low, so it restarts with each transfer.
  assign tmo = o_wb_cyc & ~i_wb_ack & (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
    end else if (!o_wb_cyc || tmo) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo   = 1'b0;
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_INIT;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_wb_we     <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_vec_valid <= 1'b0;
      o_vec_id    <= '0;
      clr_val     <= '0;
      sel_id      <= '0;
`ifdef ROCKETCPU_IRQ_DISPATCH_TIMEOUT_EN
      o_err       <= 1'b0;
`endif
    end else begin
      // Bus states launch their transfer on the first cycle with cyc low and
      // drop cyc on ack, which leaves an idle cycle before the next transfer.
      case (state)
        ST_INIT: begin
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
            o_wb_we  <= 1'b1;
            o_wb_adr <= BASE + OFS_MASK;
            o_wb_dat <= 32'(MASK_INIT);
          end else if (ack_q) begin
            o_wb_cyc <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (i_irq) state <= ST_RD_PEND;
        end
        ST_RD_PEND: begin
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
            o_wb_we  <= 1'b0;
            o_wb_adr <= BASE + OFS_PEND;
            o_wb_dat <= '0;
          end else if (ack_q) begin
            o_wb_cyc <= 1'b0;
            if (!enc_any) begin
              state <= ST_IDLE;
            end else begin
              sel_id  <= enc_idx;
              clr_val <= i_wb_rdt[SIZE-1:0] & ~(SIZE'(1) << enc_idx);
              state   <= ST_CLR;
            end
          end
        end
        ST_CLR: begin
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
            o_wb_we  <= 1'b1;
            o_wb_adr <= BASE + OFS_PEND;
            o_wb_dat <= 32'(clr_val);
          end else if (ack_q) begin
            o_wb_cyc    <= 1'b0;
            o_vec_valid <= 1'b1;
            o_vec_id    <= sel_id;
            state       <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (i_vec_ready) begin
            o_vec_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase

`ifdef ROCKETCPU_IRQ_DISPATCH_TIMEOUT_EN
      // Abandon an unacknowledged transfer; a failed mask write is retried.
      if (tmo) begin
        o_wb_cyc <= 1'b0;
        o_err    <= 1'b1;
        state    <= (state == ST_INIT) ? ST_INIT : ST_IDLE;
      end
`endif
    end
  end

endmodule

// File: doc/rocketcpu_irq_dispatch.md
RocketCPU_IRQ_DISPATCH -- requirements
Module: rocketcpu_irq_dispatch

Interface
REQ-001 SHALL have parameter SIZE, default 3, number of interrupt sources.
REQ-002 SHALL have parameter BASE, default 32'h0900_0000, pending-register address; mask register is at BASE+4.
REQ-003 SHALL have parameter MASK_INIT, default all-ones of SIZE bits, value written to the mask register after reset.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum cycles to wait for ack (used only with macro, see Configuration).
REQ-005 SHALL have ports: i_wb_clk in 1, the single clock; i_rst_n in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: o_wb_adr out 32, address; o_wb_dat out 32, write data; o_wb_we out 1, write enable; o_wb_cyc out 1, cycle request.
REQ-007 SHALL have ports: i_wb_rdt in 32, read data; i_wb_ack in 1, transfer acknowledge.
REQ-008 SHALL have ports: i_irq in 1, aggregated interrupt line from the controller.
REQ-009 SHALL have ports: o_vec_valid out 1, vector available; o_vec_id out $clog2(SIZE), source index; i_vec_ready in 1, consumer accepts vector.
REQ-010 SHALL have port o_err out 1, sticky bus-timeout flag (tied 0 without macro).

Function
REQ-011 SHALL be a Wishbone initiator: once o_wb_cyc is asserted, adr/dat/we stay stable until the cycle in which i_wb_ack=1; o_wb_cyc deasserts the next cycle.
REQ-012 SHALL keep o_wb_cyc low for at least one cycle between consecutive transfers.
REQ-013 SHALL implement FSM states INIT, IDLE, RD_PEND, CLR, DELIVER.
REQ-014 INIT: write MASK_INIT to BASE+4; on ack -> IDLE.
REQ-015 IDLE: o_wb_cyc=0; on i_irq=1 -> RD_PEND.
REQ-016 RD_PEND: read BASE; on ack capture i_wb_rdt[SIZE-1:0] as pending; pending==0 -> IDLE, else -> CLR.
REQ-017 CLR: select lowest set bit of pending (bit 0 highest priority); write pending with that bit cleared to BASE; on ack -> DELIVER.
REQ-018 DELIVER: o_vec_valid=1 and o_vec_id=selected index, both stable until i_vec_ready=1; transfer occurs when valid&ready; next cycle -> IDLE.
REQ-019 SHALL drive o_wb_dat bits above SIZE-1 to zero.
REQ-020 Remaining pending bits SHALL NOT be buffered; they are re-fetched via i_irq on return to IDLE (one vector per pass).
REQ-021 i_wb_ack arriving while o_wb_cyc=0 SHALL be ignored.
REQ-022 i_vec_ready while o_vec_valid=0 SHALL have no effect.

Reset
REQ-023 While i_rst_n=0: state=INIT with no transfer issued, o_wb_cyc=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_vec_valid=0, o_vec_id=0, o_err=0.
REQ-024 First cycle after i_rst_n rises, SHALL begin the INIT write.
REQ-025 Reset asserted mid-transfer or mid-DELIVER SHALL abort immediately; no vector is delivered; INIT repeats afterwards.

Configuration
REQ-026 Macro ROCKETCPU_IRQ_DISPATCH_TIMEOUT_EN SHALL enable a wait counter cleared at each transfer start.
REQ-027 With macro: if no ack within TIMEOUT cycles of o_wb_cyc rising, SHALL drop o_wb_cyc, set o_err=1 (sticky until reset), go to IDLE (from INIT: retry INIT).
REQ-028 Without macro: no counter, waits for ack indefinitely, o_err constant 0.

Structure
REQ-029 Shared package rocketcpu_pkg SHALL hold the FSM state enum, the BASE default and the register offsets (PEND=0, MASK=4).
REQ-030 A sub-module rocketcpu_prio_enc (SIZE-bit lowest-set-bit encoder, outputs index and any-set) is natural and SHALL be used.

Verification
REQ-031 Reset release, slave acks 2 cycles after cyc -> write 32'h7 to 0x0900_0004, then IDLE with cyc=0.
REQ-032 i_irq=1, read returns 3'b110 -> write 3'b100 to 0x0900_0000, o_vec_valid=1, o_vec_id=1.
REQ-033 o_vec_valid held with i_vec_ready=0 for 5 cycles -> id stable, no bus activity; ready=1 -> valid drops next cycle.
REQ-034 i_irq=1, read returns 0 -> no write, return to IDLE, o_vec_valid stays 0.
REQ-035 With macro, slave never acks read -> cyc drops after 16 cycles, o_err=1, stays 1 until i_rst_n=0.
REQ-036 i_rst_n low during CLR write -> cyc=0 immediately, no vector; after release INIT write reissued.
